dcd_llr_loader: RTL
===================

# dcd_llr_loader

Input stage in front of the LDPC decoder controller. It accepts channel soft values over a valid/ready stream, saturates each one to decoder LLR width, and writes one codeword of N symbols into the decoder input RAM at addresses 0..N-1. It then pulses `decode` and holds off new input until the controller reports completion. It replaces the controller's own Load-state address walk with a streamed, flow-controlled fill.

## Interface
Parameters:
- `N`, 21: codeword length; RAM addresses 0..N-1.
- `IN_W`, 8: signed input sample width.
- `LLR_W`, 6: signed LLR width written to RAM.
- `AW`, 5: RAM address width; N ≤ 2^AW is required.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: sample present.
- `in_data`  in  IN_W: signed two's-complement channel sample.
- `in_last`  in  1: marks the final sample of a frame.
- `in_ready`  out  1: loader accepts a sample this cycle.
- `ram_we`  out  1: RAM write strobe, one cycle per symbol.
- `ram_waddr`  out  AW: RAM write address.
- `ram_wdata`  out  LLR_W: saturated LLR.
- `decode`  out  1: one-cycle start pulse to the controller.
- `dec_done`  in  1: controller finished (pass or give-up), one-cycle pulse.
- `frame_err`  out  1: framing error on the current or previous frame.
- `sat_cnt`  out  clog2(N+1): number of clipped samples in the last loaded frame.

## Operation
- States: IDLE → FILL → START → BUSY → FILL.
- **IDLE**: entered only from reset. Moves to FILL after one cycle.
- **FILL**:
  - `in_ready`=1.
  - A sample is accepted when `in_valid` and `in_ready` are both 1. Each accepted sample takes the next index `idx`, counting 0..N-1.
- **Saturation**: clamp to the symmetric range ±(2^(LLR_W-1)-1), which is ±31 by default. The most negative code is never produced. `sat_cnt` increments on every clipped sample.
- **Early `in_last`** (`in_last`=1 at `idx`<N-1):
  - Sets `frame_err`.
  - Discards the partial frame: `idx`←0 and `sat_cnt`←0.
  - Stays in FILL.
  - Writes already issued for that frame stay in RAM and are overwritten by the next frame.
- **Missing `in_last`** at `idx`=N-1: sets `frame_err`, but the frame is kept and loading proceeds.
- **Frame complete**: after the sample at `idx`=N-1, go to START.
- **START**: `decode`=1 for exactly one cycle, then go to BUSY.
- **BUSY**:
  - `in_ready`=0.
  - `dec_done`=1 → FILL with `idx`←0.
  - `dec_done` outside BUSY is ignored.
- **`frame_err` clearing**: cleared when the first sample of a new frame is accepted, unless that sample itself raises an error.
- **`sat_cnt` clearing**: cleared at the first accepted sample of a frame. It holds its value through START and BUSY.

## Timing
- **Reset values**: all outputs 0; state IDLE; `idx`=0.
- **Reset mid-frame or mid-BUSY**: returns to IDLE immediately. No `decode` pulse is generated for the interrupted frame.
- **Accept-to-write latency**: 1 cycle. A sample accepted at edge t produces `ram_we`=1 with `ram_waddr`/`ram_wdata` registered during cycle t+1.
- **Last sample to `decode`**:
  - Last sample accepted at t.
  - Its write happens in cycle t+1, concurrent with state START.
  - `decode` is high in cycle t+1, after the final write has been presented.
  - The controller samples `decode` at the edge ending t+1, when the write is committed.
- **`in_ready` timing**:
  - Registered from state; it drops in the cycle after the N-th acceptance.
  - It rises in the cycle after `dec_done` is sampled.
- **Throughput**: full rate, one sample per cycle during FILL. Minimum frame period is N+2 cycles plus decoder time.
- **Simultaneous `in_last` and `in_valid`=0**: no effect; `in_last` is qualified by acceptance.

## Structure
- **Shared `dcd_pkg`**:
  - Parameters `N`, `LLR_W`, `AW`.
  - Loader state enum.
  - Function computing the saturation limit.
  - The controller uses the same `N`/`AW` constants.
- **Sub-module `dcd_llr_sat`**:
  - Combinational.
  - In: `IN_W` sample. Out: `LLR_W` LLR and a clip flag.
  - Instantiated once.

## Test plan
- Reset, then stream 21 samples 0..20 back-to-back with `in_last` on the 21st:
  - `ram_we` 21 consecutive cycles, addresses 0..20, data 0..20.
  - `decode` one cycle, coincident with the address-20 write.
  - `in_ready`=0 until `dec_done`.
- Samples 100, -128, -32, 31, -31, 17:
  - Written as 31, -31, -31, 31, -31, 17.
  - `sat_cnt`=3 after the frame.
- `in_last` on the 10th sample:
  - `frame_err`=1, no `decode`.
  - The next 21-sample frame starts writing at address 0 and clears `frame_err` on its first sample.
- 21 samples with no `in_last`: `frame_err`=1 and `decode` still pulses.
- Randomly toggled `in_valid` gaps: writes remain in order 0..20 with no duplicates; `decode` occurs exactly once.
- Assert `rst` in the middle of FILL (`idx`=12) and again in BUSY:
  - All outputs 0 immediately.
  - After release, one IDLE cycle, then `in_ready`=1.
  - No `decode` is issued until a full new frame is received.

Source files
------------

// File: rtl/dcd_pkg.sv
// Shared constants, loader state encoding and saturation helper for the LDPC decoder front end.
package dcd_pkg;

   // Codeword geometry shared with the decoder controller.
   localparam int unsigned N     = 21;
   localparam int unsigned LLR_W = 6;
   localparam int unsigned AW    = 5;

   // Loader sequencing: IDLE only follows reset, then FILL/START/BUSY loop.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFill  = 2'd1,
      StStart = 2'd2,
      StBusy  = 2'd3
   } ld_state_e;

   // Largest magnitude representable symmetrically in llr_w bits (most negative code excluded).
   function automatic int sat_limit(input int unsigned llr_w);
      return (1 << (llr_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/dcd_llr_sat.sv
// Combinational clamp of a signed channel sample to the symmetric LLR range.
module dcd_llr_sat import dcd_pkg::*; #(
   parameter int unsigned IN_W  = 8,
   parameter int unsigned LLR_W = dcd_pkg::LLR_W
) (
   input  logic [IN_W-1:0]  sample_i,
   output logic [LLR_W-1:0] llr_o,
   output logic             clip_o
);

   localparam int Lim = sat_limit(LLR_W);

   logic signed [31:0] sample_ext;

   // Sign-extend once, then compare against +/-Lim in a common 32-bit signed domain.
   always_comb begin
      sample_ext = 32'(signed'(sample_i));
      llr_o      = sample_ext[LLR_W-1:0];
      clip_o     = 1'b0;
      if (sample_ext > Lim) begin
         llr_o  = LLR_W'(Lim);
         clip_o = 1'b1;
      end else if (sample_ext < -Lim) begin
         llr_o  = LLR_W'(-Lim);
         clip_o = 1'b1;
      end
   end

endmodule

// File: rtl/dcd_llr_loader.sv
// Streams one codeword of saturated LLRs into the decoder input RAM, then kicks off a decode
// and holds off input until the controller reports completion.
module dcd_llr_loader import dcd_pkg::*; #(
   parameter int unsigned N     = dcd_pkg::N,
   parameter int unsigned IN_W  = 8,
   parameter int unsigned LLR_W = dcd_pkg::LLR_W,
   parameter int unsigned AW    = dcd_pkg::AW,
   localparam int unsigned CntW = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             ram_we,
   output logic [AW-1:0]    ram_waddr,
   output logic [LLR_W-1:0] ram_wdata,
   output logic             decode,
   input  logic             dec_done,
   output logic             frame_err,
   output logic [CntW-1:0]  sat_cnt
);

   localparam logic [AW-1:0] LastIdx = AW'(N - 1);

   ld_state_e        state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic             ready_q;
   logic             decode_q;
   logic             we_q, we_d;
   logic [AW-1:0]    waddr_q, waddr_d;
   logic [LLR_W-1:0] wdata_q, wdata_d;
   logic             err_q, err_d;
   logic [CntW-1:0]  sat_q, sat_d;
   logic [CntW-1:0]  sat_base;

   logic             accept;
   logic             idx_first;
   logic             idx_last;
   logic             early_last;
   logic             missing_last;
   logic [LLR_W-1:0] llr;
   logic             clip;

   dcd_llr_sat #(
      .IN_W  (IN_W),
      .LLR_W (LLR_W)
   ) u_sat (
      .sample_i (in_data),
      .llr_o    (llr),
      .clip_o   (clip)
   );

   // ready_q is only ever high in FILL, so it alone qualifies acceptance.
   assign accept       = in_valid & ready_q;
   assign idx_first    = (idx_q == '0);
   assign idx_last     = (idx_q == LastIdx);
   assign early_last   = in_last & ~idx_last;
   assign missing_last = ~in_last & idx_last;

   // Next-state logic for the load sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  state_d = StFill;
         StFill:  if (accept && idx_last) state_d = StStart;
         StStart: state_d = StBusy;
         StBusy:  if (dec_done) state_d = StFill;
         default: state_d = StIdle;
      endcase
   end

   // Per-sample datapath: write capture, symbol index, clip count and framing error.
   always_comb begin
      idx_d    = idx_q;
      we_d     = accept;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      sat_d    = sat_q;
      sat_base = idx_first ? '0 : sat_q;
      if (accept) begin
         waddr_d = idx_q;
         wdata_d = llr;
         sat_d   = sat_base + CntW'(clip);
         // A new frame clears the sticky error unless its own first sample is bad.
         err_d   = idx_first ? 1'b0 : err_q;
         if (early_last || missing_last) begin
            err_d = 1'b1;
         end
         if (early_last) begin
            // Partial frame is dropped; its RAM contents get overwritten by the next one.
            idx_d = '0;
            sat_d = '0;
         end else if (idx_last) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + AW'(1);
         end
      end
      if (state_q == StBusy && dec_done) begin
         idx_d = '0;
      end
   end

   // State and output registers; all outputs are registered so they are glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         ready_q  <= 1'b0;
         decode_q <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         sat_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         ready_q  <= (state_d == StFill);
         decode_q <= (state_d == StStart);
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         sat_q    <= sat_d;
      end
   end

   assign in_ready  = ready_q;
   assign decode    = decode_q;
   assign ram_we    = we_q;
   assign ram_waddr = waddr_q;
   assign ram_wdata = wdata_q;
   assign frame_err = err_q;
   assign sat_cnt   = sat_q;

endmodule
